wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//   Arbitrates the single register-file write port between the MEM/WB pipeline writeback and a long-latency result source (divider/miss refill).
//   Holds a pending-register scoreboard so ID can stall on RAW/WAW hazards against in-flight long ops.
//   Sits between the MEM/WB stage register, the long-latency unit and the register file, one instance per core.
// PARAMETERS
//   CORE          0   core index, informational only
//   DATA_WIDTH    32  register data width
//   LQ_DEPTH      4   long-latency result FIFO depth (power of 2, >=2)
//   STARVE_LIMIT  8   consecutive preempted cycles before wb_hold asserts
// PORTS
//   clock          in   1          single clock, rising edge
//   reset          in   1          asynchronous, active-high
//   wb_regWrite    in   1          pipeline WB write request
//   wb_rd          in   5          pipeline WB destination
//   wb_write_data  in   DATA_WIDTH pipeline WB data
//   lu_valid       in   1          long-latency result valid
//   lu_rd          in   5          long-latency result destination
//   lu_data        in   DATA_WIDTH long-latency result data
//   lu_ready       out  1          FIFO can accept (count < LQ_DEPTH)
//   issue_valid    in   1          long op issued this cycle; mark issue_rd pending
//   issue_rd       in   5          destination of issued long op
//   id_rs1,id_rs2  in   5 each     ID-stage source registers
//   id_rd          in   5          ID-stage destination register
//   stall          out  1          ID must stall
//   wb_hold        out  1          request pipeline bubble (wb_regWrite=0) next cycle
//   rf_write       out  1          register-file write enable (registered)
//   rf_write_reg   out  5          register-file write address (registered)
//   rf_write_data  out  DATA_WIDTH register-file write data (registered)
//   pending        out  32         scoreboard, bit n = reg n awaiting long result
// BEHAVIOUR
//   Reset (async, any time): rf_write=0, rf_write_reg=0, rf_write_data=0, pending=0, FIFO flushed, starve counter=0,
//     wb_hold=0; lu_ready=1 after reset deasserts. In-flight long results are lost; the issuing side is reset too.
//   Push: lu_valid && lu_ready -> enqueue {lu_rd,lu_data}. lu_ready depends on count only; no push-when-full even with pop.
//   Selection each cycle (priority): 1) wb_regWrite && wb_rd!=0 -> WB; 2) FIFO non-empty -> pop head; 3) idle.
//   Winner registered into rf_* at the clock edge: 1-cycle latency from selection. Idle -> rf_write=0, rf_write_reg/data hold.
//   Entry pushed in cycle N is poppable no earlier than N+1: lu accept to rf_write high >= 2 cycles.
//   Popped entry with rd==0: discarded, rf_write=0, no pending change. WB with rd==0 never wins and never blocks pop.
//   Scoreboard: issue_valid && issue_rd!=0 sets pending[issue_rd]; pop of rd clears pending[rd] at the same edge rf_write rises.
//     Same-cycle set and clear of one register: set wins. pending[0] always 0. WB writes never touch pending.
//   stall = (id_rs1!=0 && pending[id_rs1]) | (id_rs2!=0 && pending[id_rs2]) | (id_rd!=0 && pending[id_rd]); combinational from registered pending.
//   Starvation: counter increments each cycle FIFO non-empty and WB wins; clears on pop or empty; saturates at STARVE_LIMIT.
//     wb_hold = (counter == STARVE_LIMIT), registered; drops the cycle after a pop. WB still wins if the pipeline ignores wb_hold.
//   FIFO pointers wrap modulo LQ_DEPTH; count in $clog2(LQ_DEPTH)+1 bits.
// STRUCTURE
//   Shared package: REG_ADDR_W=5, NUM_REGS=32, typedef wb_req_t {rd[4:0], data[DATA_WIDTH-1:0]}.
//   Sub-module: wb_result_fifo (LQ_DEPTH x wb_req_t, push/pop/full/empty/count, async reset).
//   Top: priority select, output register, scoreboard, starve counter, stall logic.
// TESTING
//   Reset mid-stream with 3 FIFO entries and pending=0x0000_0006 -> next cycle pending=0, rf_write=0, lu_ready=1, no pops.
//   lu push rd=5 data=0xDEAD_BEEF, no WB -> rf_write=1, reg=5, data=0xDEAD_BEEF 2 cycles after accept; pending[5] clears same edge.
//   WB rd=3 and FIFO head rd=7 same cycle -> rf_write_reg=3 first, rd=7 the following cycle.
//   Push 4 entries with WB busy -> lu_ready=0; WB every cycle for 8 cycles -> wb_hold=1; one idle WB cycle -> pop, wb_hold=0 next cycle.
//   issue rd=9; ID rs2=9 -> stall=1; issue rd=9 same cycle as pop rd=9 -> pending[9] stays 1, stall stays 1.
//   lu rd=0 and issue rd=0 -> pending unchanged, popped entry discarded, rf_write=0; id_rs1=0 never stalls.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter_pkg
// Brief    : Shared widths and request type for the writeback port arbiter.
// Revision : 1.0
// ============================================================================
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int WB_DATA_W  = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter_if
// Brief    : Pipeline WB, long-latency unit, ID and register-file signals.
// Revision : 1.0
// ============================================================================
interface wb_port_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    import wb_port_arbiter_pkg::*;

    logic                  wb_regWrite;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_write_data;
    logic                  lu_valid;
    logic [REG_ADDR_W-1:0] lu_rd;
    logic [DATA_WIDTH-1:0] lu_data;
    logic                  lu_ready;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  stall;
    logic                  wb_hold;
    logic                  rf_write;
    logic [REG_ADDR_W-1:0] rf_write_reg;
    logic [DATA_WIDTH-1:0] rf_write_data;
    logic [NUM_REGS-1:0]   pending;

    modport slave (
        input  wb_regWrite, wb_rd, wb_write_data,
        input  lu_valid, lu_rd, lu_data,
        input  issue_valid, issue_rd,
        input  id_rs1, id_rs2, id_rd,
        output lu_ready, stall, wb_hold,
        output rf_write, rf_write_reg, rf_write_data, pending
    );

    modport master (
        output wb_regWrite, wb_rd, wb_write_data,
        output lu_valid, lu_rd, lu_data,
        output issue_valid, issue_rd,
        output id_rs1, id_rs2, id_rd,
        input  lu_ready, stall, wb_hold,
        input  rf_write, rf_write_reg, rf_write_data, pending
    );

endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_result_fifo
// Brief    : Long-latency result queue; entries become visible the cycle after push.
// Revision : 1.0
// ============================================================================
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                          clock,
    input  wire logic                          reset,
    input  wire logic                          i_push,
    input  wire logic [REG_ADDR_W-1:0]         i_push_rd,
    input  wire logic [DATA_WIDTH-1:0]         i_push_data,
    input  wire logic                          i_pop,
    output logic      [REG_ADDR_W-1:0]         o_head_rd,
    output logic      [DATA_WIDTH-1:0]         o_head_data,
    output logic                               o_full,
    output logic                               o_empty,
    output logic      [$clog2(DEPTH):0]        o_count
);
    localparam int                c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w+1)'(DEPTH);

    logic [REG_ADDR_W-1:0] r_mem_rd   [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w:0]      r_count;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    assign o_full      = (r_count == c_depth);
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_head_rd   = r_mem_rd[r_rd_ptr];
    assign o_head_data = r_mem_data[r_rd_ptr];

    // Push is refused when full even if a pop frees a slot this cycle.
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem_rd[r_wr_ptr]   <= i_push_rd;
            r_mem_data[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Brief    : Register-file write port arbiter with pending-register scoreboard.
// Revision : 1.0
// ============================================================================
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int LQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  wire logic        clock,
    input  wire logic        reset,
    wb_port_arbiter_if.slave bus
);
    localparam int                   c_cnt_w      = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0]   c_starve_max = c_cnt_w'(STARVE_LIMIT);
    localparam int                   c_lq_cnt_w   = $clog2(LQ_DEPTH) + 1;
    localparam logic [c_lq_cnt_w-1:0] c_lq_depth  = c_lq_cnt_w'(LQ_DEPTH);

    generate
        if (CORE < 0 || LQ_DEPTH < 2 || (LQ_DEPTH & (LQ_DEPTH - 1)) != 0) begin : g_bad_param
            $error("wb_port_arbiter: LQ_DEPTH must be a power of 2 >= 2");
        end
    endgenerate

    logic                    w_wb_sel;
    logic                    w_pop;
    logic                    w_push;
    logic [REG_ADDR_W-1:0]   w_head_rd;
    logic [DATA_WIDTH-1:0]   w_head_data;
    logic                    w_full;
    logic                    w_empty;
    logic [c_lq_cnt_w-1:0]   w_count;
    logic [NUM_REGS-1:0]     w_pending_next;
    logic [c_cnt_w-1:0]      w_starve_next;

    logic                    r_rf_write;
    logic [REG_ADDR_W-1:0]   r_rf_write_reg;
    logic [DATA_WIDTH-1:0]   r_rf_write_data;
    logic [NUM_REGS-1:0]     r_pending;
    logic [c_cnt_w-1:0]      r_starve_cnt;
    logic                    r_wb_hold;

    // A WB write to x0 is a no-op and must not steal the port from the queue.
    assign w_wb_sel = bus.wb_regWrite && (bus.wb_rd != '0);
    assign w_pop    = !w_wb_sel && !w_empty;
    assign w_push   = bus.lu_valid && !w_full;

    wb_result_fifo #(
        .DEPTH      (LQ_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_rd   (bus.lu_rd),
        .i_push_data (bus.lu_data),
        .i_pop       (w_pop),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    // A new issue to a register outranks the retirement of an older op to it.
    always_comb begin
        w_pending_next = r_pending;
        if (w_pop && (w_head_rd != '0)) begin
            w_pending_next[w_head_rd] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != '0)) begin
            w_pending_next[bus.issue_rd] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
    end

    always_comb begin
        w_starve_next = '0;
        if (!w_empty && w_wb_sel) begin
            w_starve_next = (r_starve_cnt == c_starve_max) ? c_starve_max
                                                            : r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rf_write      <= 1'b0;
            r_rf_write_reg  <= '0;
            r_rf_write_data <= '0;
            r_pending       <= '0;
            r_starve_cnt    <= '0;
            r_wb_hold       <= 1'b0;
        end else begin
            r_pending    <= w_pending_next;
            r_starve_cnt <= w_starve_next;
            r_wb_hold    <= (w_starve_next == c_starve_max);
            if (w_wb_sel) begin
                r_rf_write      <= 1'b1;
                r_rf_write_reg  <= bus.wb_rd;
                r_rf_write_data <= bus.wb_write_data;
            end else if (w_pop && (w_head_rd != '0)) begin
                r_rf_write      <= 1'b1;
                r_rf_write_reg  <= w_head_rd;
                r_rf_write_data <= w_head_data;
            end else begin
                r_rf_write      <= 1'b0;
            end
        end
    end

    function automatic logic reg_busy(input logic [REG_ADDR_W-1:0] r,
                                      input logic [NUM_REGS-1:0]   pend);
        return (r != '0) && pend[r];
    endfunction

    assign bus.stall = reg_busy(bus.id_rs1, r_pending) |
                       reg_busy(bus.id_rs2, r_pending) |
                       reg_busy(bus.id_rd,  r_pending);

    assign bus.lu_ready      = (w_count < c_lq_depth);
    assign bus.wb_hold       = r_wb_hold;
    assign bus.rf_write      = r_rf_write;
    assign bus.rf_write_reg  = r_rf_write_reg;
    assign bus.rf_write_data = r_rf_write_data;
    assign bus.pending       = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Brief    : Directed and randomized checks of wb_port_arbiter against a queue model.
// Revision : 1.0
// ============================================================================
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int c_dw    = 32;
    localparam int c_depth = 4;
    localparam int c_limit = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    wb_port_arbiter_if #(.DATA_WIDTH(c_dw)) bus ();

    wb_port_arbiter #(
        .CORE         (0),
        .DATA_WIDTH   (c_dw),
        .LQ_DEPTH     (c_depth),
        .STARVE_LIMIT (c_limit)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: result queue, pending set, write-port outputs.
    bit [31:0] m_pend;
    int        m_qrd[$];
    bit [31:0] m_qdata[$];
    bit        m_rfw;
    bit [4:0]  m_rfreg;
    bit [31:0] m_rfdata;
    int        m_starve;
    bit        m_hold;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_qrd.delete(); m_qdata.delete();
        m_rfw = 0; m_rfreg = '0; m_rfdata = '0; m_starve = 0; m_hold = 0;
    endtask

    task automatic drive_idle();
        bus.wb_regWrite = 0; bus.wb_rd = '0; bus.wb_write_data = '0;
        bus.lu_valid = 0; bus.lu_rd = '0; bus.lu_data = '0;
        bus.issue_valid = 0; bus.issue_rd = '0;
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    endtask

    task automatic cycle(input bit wbw, input bit [4:0] wrd, input bit [31:0] wdata,
                         input bit luv, input bit [4:0] lrd, input bit [31:0] ldata,
                         input bit iv, input bit [4:0] ird,
                         input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] idrd);
        bit wb_sel;
        int had;
        int prd;
        bit [31:0] pd;
        bit exp_stall;
        @(negedge clock);
        bus.wb_regWrite = wbw; bus.wb_rd = wrd; bus.wb_write_data = wdata;
        bus.lu_valid = luv; bus.lu_rd = lrd; bus.lu_data = ldata;
        bus.issue_valid = iv; bus.issue_rd = ird;
        bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = idrd;
        #1;
        exp_stall = (rs1 != 0 && m_pend[rs1]) || (rs2 != 0 && m_pend[rs2]) ||
                    (idrd != 0 && m_pend[idrd]);
        check("stall", bus.stall, exp_stall);
        check("lu_ready", bus.lu_ready, m_qrd.size() < c_depth);

        wb_sel = wbw && (wrd != 0);
        had    = m_qrd.size();
        if (wb_sel) begin
            m_rfw = 1; m_rfreg = wrd; m_rfdata = wdata;
        end else if (had > 0) begin
            prd = m_qrd.pop_front();
            pd  = m_qdata.pop_front();
            if (prd != 0) begin
                m_rfw = 1; m_rfreg = prd[4:0]; m_rfdata = pd; m_pend[prd] = 0;
            end else begin
                m_rfw = 0;
            end
        end else begin
            m_rfw = 0;
        end
        if (iv && ird != 0) m_pend[ird] = 1;
        if (luv && had < c_depth) begin
            m_qrd.push_back(int'(lrd));
            m_qdata.push_back(ldata);
        end
        m_starve = (had > 0 && wb_sel) ? ((m_starve + 1 > c_limit) ? c_limit : m_starve + 1) : 0;
        m_hold   = (m_starve == c_limit);

        @(posedge clock);
        #1;
        check("rf_write", bus.rf_write, m_rfw);
        check("rf_write_reg", bus.rf_write_reg, m_rfreg);
        check("rf_write_data", bus.rf_write_data, m_rfdata);
        check("pending", bus.pending, m_pend);
        check("wb_hold", bus.wb_hold, m_hold);
    endtask

    task automatic idle_cycle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int wbp;
        bit [4:0] wrd, lrd;
        drive_idle();
        model_reset();
        repeat (3) @(negedge clock);
        reset = 0;
        #1;
        check("reset_rf_write", bus.rf_write, 0);
        check("reset_rf_reg", bus.rf_write_reg, 0);
        check("reset_rf_data", bus.rf_write_data, 0);
        check("reset_pending", bus.pending, 0);
        check("reset_wb_hold", bus.wb_hold, 0);
        check("reset_lu_ready", bus.lu_ready, 1);

        // Long result to r5 retires two cycles after acceptance.
        cycle(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        cycle(0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 5);
        check("lu_accept_no_write", bus.rf_write, 0);
        idle_cycle();
        check("lu_write", bus.rf_write, 1);
        check("lu_reg5", bus.rf_write_reg, 5);
        check("lu_data", bus.rf_write_data, 32'hDEAD_BEEF);
        check("pend5_clear", bus.pending[5], 0);

        // WB wins over a queued result, which follows next cycle.
        cycle(0, 0, 0, 1, 7, 32'h0000_0777, 0, 0, 0, 0, 0);
        cycle(1, 3, 32'h0000_0333, 0, 0, 0, 0, 0, 0, 0, 0);
        check("wb_first", bus.rf_write_reg, 3);
        idle_cycle();
        check("lu_second", bus.rf_write_reg, 7);

        // Starvation: fill the queue under constant WB traffic.
        for (int i = 0; i < 12; i++) begin
            cycle(1, 1, 32'h100 + i, i < 4, 5'(10 + i), 32'hA0 + i, 0, 0, 0, 0, 0);
            if (i == 3) check("lu_ready_full", bus.lu_ready, 0);
        end
        check("wb_hold_set", bus.wb_hold, 1);
        idle_cycle();
        check("pop_after_hold", bus.rf_write_reg, 10);
        check("wb_hold_drop", bus.wb_hold, 0);
        repeat (4) idle_cycle();

        // Re-issue to r9 on the same edge as its retirement keeps it pending.
        cycle(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        cycle(0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 9, 0);
        check("stall_rs2_9", bus.stall, 1);
        cycle(0, 0, 0, 0, 0, 0, 1, 9, 0, 9, 0);
        check("reissue_pend9", bus.pending[9], 1);
        check("reissue_reg9", bus.rf_write_reg, 9);
        check("reissue_stall", bus.stall, 1);

        // Writes and issues to x0.
        cycle(0, 0, 0, 1, 0, 32'h1234, 1, 0, 0, 0, 0);
        cycle(1, 0, 32'h5555, 0, 0, 0, 0, 0, 0, 0, 0);
        check("x0_discard", bus.rf_write, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-stream with three queued results and r1/r2 pending.
        cycle(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        idle_cycle();
        model_reset();
        @(negedge clock); reset = 1; #1; @(negedge clock); reset = 0;
        cycle(1, 20, 32'h20, 1, 10, 32'hB0, 1, 1, 0, 0, 0);
        cycle(1, 21, 32'h21, 1, 11, 32'hB1, 1, 2, 0, 0, 0);
        cycle(1, 22, 32'h22, 1, 12, 32'hB2, 0, 0, 0, 0, 0);
        check("pre_reset_pend", bus.pending, 32'h6);
        @(negedge clock);
        drive_idle();
        reset = 1;
        #1;
        check("midreset_pending", bus.pending, 0);
        check("midreset_rf_write", bus.rf_write, 0);
        check("midreset_wb_hold", bus.wb_hold, 0);
        @(negedge clock);
        reset = 0;
        model_reset();
        idle_cycle();
        check("postreset_no_pop", bus.rf_write, 0);
        check("postreset_lu_ready", bus.lu_ready, 1);

        // Randomized traffic across load profiles.
        for (int seg = 0; seg < 40; seg++) begin
            case (seg % 4)
                0:       wbp = 20;
                1:       wbp = 60;
                2:       wbp = 100;
                default: wbp = 0;
            endcase
            for (int c = 0; c < 60; c++) begin
                wrd = 5'($urandom_range(0, 31));
                if (wbp == 100 && wrd == 0) wrd = 5'd17;
                lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                cycle(($urandom_range(1, 100) <= wbp), wrd, $urandom(),
                      ($urandom_range(0, 1) == 1), lrd, $urandom(),
                      ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 15)),
                      5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                      5'($urandom_range(0, 15)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
